lif_layer: RTL and testbench
============================

LIF_LAYER -- requirements
Module: lif_layer

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: number of presynaptic spike lines.
REQ-002 SHALL have parameter NUM_NODES, default 4: number of neurons; matches the winner-selection stage width.
REQ-003 SHALL have parameter WEIGHT_W, default 8: signed synaptic weight width.
REQ-004 SHALL have parameter POT_W, default 16: signed membrane potential width.
REQ-005 SHALL have parameter THRESHOLD, default 100: firing threshold, positive, fits in POT_W.
REQ-006 SHALL have parameter LEAK_SHIFT, default 3: leak is v >>> LEAK_SHIFT per cycle.
REQ-007 SHALL have parameter REFRAC_CYCLES, default 2: refractory length in cycles.
REQ-008 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-010 SHALL have port spikes_i, input, NUM_INPUTS: presynaptic spikes sampled every cycle.
REQ-011 SHALL have port weight_we_i, input, 1: weight write strobe.
REQ-012 SHALL have port weight_node_i, input, clog2(NUM_NODES): target neuron of the write.
REQ-013 SHALL have port weight_input_i, input, clog2(NUM_INPUTS): target synapse of the write.
REQ-014 SHALL have port weight_data_i, input, WEIGHT_W: signed weight value.
REQ-015 SHALL have port nodes_o, output, NUM_NODES: registered one-cycle output spikes per neuron, feeding winner_selection.nodes_i.

Function
REQ-016 Per neuron, syn = signed sum of weight[n][j] over all j with spikes_i[j]=1; width POT_W+clog2(NUM_INPUTS)+1, no overflow.
REQ-017 v_next = v - (v >>> LEAK_SHIFT) + syn, computed at full width, then clamped to [0, 2^(POT_W-1)-1].
REQ-018 v_next >= THRESHOLD: nodes_o[n]=1 on the next cycle, v <= 0, refractory counter <= REFRAC_CYCLES.
REQ-019 Otherwise: v <= v_next and nodes_o[n] <= 0.
REQ-020 Latency: a spike on spikes_i at cycle t contributes to nodes_o at cycle t+1 at the earliest.
REQ-021 Refractory counter nonzero: syn is ignored, v is held at 0, no spike, counter decrements by 1 per cycle.
REQ-022 Weight write takes effect on the following cycle; a same-cycle integration uses the old weight.
REQ-023 Out-of-range weight_node_i or weight_input_i writes are ignored.
REQ-024 Neurons are independent; several may spike in the same cycle.

Reset
REQ-025 With rst_i=1 at a clock edge: all v=0, all refractory counters=0, nodes_o=0, all weights=0.
REQ-026 Reset mid-operation discards pending potential and refractory state; the first integration happens on the first cycle with rst_i=0.

Configuration
REQ-027 Macro LIF_REFRACTORY_EN defined: refractory behaviour per REQ-018/REQ-021.
REQ-028 Macro LIF_REFRACTORY_EN undefined: no counters are built and REFRAC_CYCLES is ignored; after a spike v resets to 0 and integrates the next cycle, so consecutive-cycle spikes are possible.

Structure
REQ-029 Shared package snn_pkg SHALL hold the potential/weight typedefs and a saturating clamp function, reused by winner_selection counters.
REQ-030 Sub-module lif_neuron SHALL hold one neuron (potential register, leak, threshold, refractory counter), instantiated NUM_NODES times; lif_layer holds the weight array and synaptic sums.

Verification (defaults; cycle 0 is the first cycle after reset release)
REQ-031 Bench SHALL cover: w[0][0]=60, spikes_i=0001 each cycle -> v0=60 then 113, nodes_o[0]=1 at cycle 2, v0=0.
REQ-032 Bench SHALL cover: after the REQ-031 spike with spikes_i held -> nodes_o[0]=0 for 2 cycles, v0 stays 0, integration resumes on the third cycle (LIF_REFRACTORY_EN defined).
REQ-033 Bench SHALL cover: w[1][0]=-50, v1=0, spike on input 0 -> v1 clamps at 0, no spike.
REQ-034 Bench SHALL cover: w[2][0..3]=127, spikes_i=1111 -> syn=508 at full width, nodes_o[2]=1 next cycle.
REQ-035 Bench SHALL cover: v0=80 with rst_i pulsed for 1 cycle -> v0=0, nodes_o=0, weights=0.
REQ-036 Bench SHALL cover: weight write to w[0][0] in the same cycle as spikes_i[0]=1 -> the old weight is used that cycle and the new weight from the next.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared spiking-network types and helpers: potential/weight typedefs, index-width helper
// and the saturating clamp used by lif_neuron and the winner_selection counters.
package snn_pkg;

   localparam int DEF_POT_W    = 16;
   localparam int DEF_WEIGHT_W = 8;
   localparam int CLAMP_W      = 64;

   typedef logic signed [DEF_POT_W-1:0]    potential_t;
   typedef logic signed [DEF_WEIGHT_W-1:0] weight_t;
   typedef logic signed [CLAMP_W-1:0]      wide_t;

   // Callers sign-extend into wide_t, clamp, then truncate back to their own width.
   function automatic wide_t sat_clamp(input wide_t x, input wide_t lo, input wide_t hi);
      wide_t r;
      r = x;
      if (x < lo) begin
         r = lo;
      end else if (x > hi) begin
         r = hi;
      end
      return r;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: potential register, shift leak, threshold and,
// when LIF_REFRACTORY_EN is defined, a refractory down-counter.
module lif_neuron
   import snn_pkg::*;
#(
   parameter int POT_W         = 16,
   parameter int SYN_W         = 19,
   parameter int THRESHOLD     = 100,
   parameter int LEAK_SHIFT    = 3,
   parameter int REFRAC_CYCLES = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic signed [SYN_W-1:0] syn_i,
   output logic                    spike_o,
   output logic [POT_W-1:0]        v_o
);

   localparam int    CALC_W   = SYN_W + 2;
   localparam wide_t THRESH_W = wide_t'(THRESHOLD);
   localparam wide_t POT_MAX  = (wide_t'(1) <<< (POT_W - 1)) - wide_t'(1);

   logic signed [POT_W-1:0]  v_q, v_d;
   logic                     spike_q, spike_d;
   logic signed [CALC_W-1:0] v_ext, leak, v_full;
   wide_t                    v_sat;

   // Full-width integration; the clamp keeps the stored potential non-negative.
   always_comb begin
      v_ext  = CALC_W'(v_q);
      leak   = v_ext >>> LEAK_SHIFT;
      v_full = v_ext - leak + CALC_W'(syn_i);
      v_sat  = sat_clamp(wide_t'(v_full), '0, POT_MAX);
   end

`ifdef LIF_REFRACTORY_EN
   localparam int RC_W = idx_w(REFRAC_CYCLES + 1);

   logic [RC_W-1:0] refrac_q, refrac_d;

   always_comb begin
      v_d      = '0;
      spike_d  = 1'b0;
      refrac_d = '0;
      if (refrac_q != '0) begin
         refrac_d = refrac_q - RC_W'(1);
      end else if (v_sat >= THRESH_W) begin
         spike_d  = 1'b1;
         refrac_d = RC_W'(REFRAC_CYCLES);
      end else begin
         v_d = POT_W'(v_sat);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         refrac_q <= '0;
      end else begin
         refrac_q <= refrac_d;
      end
   end
`else
   always_comb begin
      v_d     = '0;
      spike_d = 1'b0;
      if (v_sat >= THRESH_W) begin
         spike_d = 1'b1;
      end else begin
         v_d = POT_W'(v_sat);
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v_q     <= '0;
         spike_q <= 1'b0;
      end else begin
         v_q     <= v_d;
         spike_q <= spike_d;
      end
   end

   assign spike_o = spike_q;
   assign v_o     = v_q;

endmodule

// File: rtl/lif_layer.sv
// Layer of LIF neurons: weight memory, per-neuron synaptic sums and NUM_NODES lif_neuron
// instances. Refractory behaviour is enabled by defining LIF_REFRACTORY_EN.
module lif_layer
   import snn_pkg::*;
#(
   parameter int NUM_INPUTS    = 4,
   parameter int NUM_NODES     = 4,
   parameter int WEIGHT_W      = 8,
   parameter int POT_W         = 16,
   parameter int THRESHOLD     = 100,
   parameter int LEAK_SHIFT    = 3,
   parameter int REFRAC_CYCLES = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NUM_INPUTS-1:0]            spikes_i,
   input  logic                             weight_we_i,
   input  logic [idx_w(NUM_NODES)-1:0]      weight_node_i,
   input  logic [idx_w(NUM_INPUTS)-1:0]     weight_input_i,
   input  logic signed [WEIGHT_W-1:0]       weight_data_i,
   output logic [NUM_NODES-1:0]             nodes_o
);

   localparam int NODE_IDX_W = idx_w(NUM_NODES);
   localparam int IN_IDX_W   = idx_w(NUM_INPUTS);
   localparam int SYN_W      = POT_W + $clog2(NUM_INPUTS) + 1;

   logic signed [WEIGHT_W-1:0] weight_q [NUM_NODES][NUM_INPUTS];
   logic signed [SYN_W-1:0]    syn_w    [NUM_NODES];
   logic [POT_W-1:0]           v_dbg    [NUM_NODES];

   // Equality decode: an index with no matching (node, input) pair writes nothing.
   always_ff @(posedge clk_i) begin
      for (int n = 0; n < NUM_NODES; n++) begin
         for (int j = 0; j < NUM_INPUTS; j++) begin
            if (rst_i) begin
               weight_q[n][j] <= '0;
            end else if (weight_we_i && (weight_node_i == NODE_IDX_W'(n))
                         && (weight_input_i == IN_IDX_W'(j))) begin
               weight_q[n][j] <= weight_data_i;
            end
         end
      end
   end

   always_comb begin
      for (int n = 0; n < NUM_NODES; n++) begin
         syn_w[n] = '0;
         for (int j = 0; j < NUM_INPUTS; j++) begin
            if (spikes_i[j]) begin
               syn_w[n] = syn_w[n] + SYN_W'(weight_q[n][j]);
            end
         end
      end
   end

   for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
      lif_neuron #(
         .POT_W         (POT_W),
         .SYN_W         (SYN_W),
         .THRESHOLD     (THRESHOLD),
         .LEAK_SHIFT    (LEAK_SHIFT),
         .REFRAC_CYCLES (REFRAC_CYCLES)
      ) u_neuron (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .syn_i   (syn_w[n]),
         .spike_o (nodes_o[n]),
         .v_o     (v_dbg[n])
      );
   end

endmodule

// File: tb/tb_lif_layer.sv
// Directed bench for lif_layer with default parameters; expectations follow
// LIF_REFRACTORY_EN when the macro is defined for the build.
module tb_lif_layer;

   logic              clk;
   logic              rst;
   logic [3:0]        spikes;
   logic              we;
   logic [1:0]        w_node;
   logic [1:0]        w_input;
   logic signed [7:0] w_data;
   logic [3:0]        nodes;

   int checks   = 0;
   int failures = 0;

   lif_layer dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .spikes_i       (spikes),
      .weight_we_i    (we),
      .weight_node_i  (w_node),
      .weight_input_i (w_input),
      .weight_data_i  (w_data),
      .nodes_o        (nodes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic write_weight(input int n, input int j, input int d);
      we      = 1'b1;
      w_node  = 2'(n);
      w_input = 2'(j);
      w_data  = 8'(d);
      tick();
      we      = 1'b0;
   endtask

   initial begin
      rst = 1'b1; spikes = '0; we = 1'b0; w_node = '0; w_input = '0; w_data = '0;

      // Reset state
      reset_dut();
      check("rst_nodes", nodes, 0);
      check("rst_v0", dut.g_node[0].u_neuron.v_q, 0);
      check("rst_w00", dut.weight_q[0][0], 0);

      // Integrate to threshold, then refractory / immediate re-integration
      write_weight(0, 0, 60);
      check("w00_60", dut.weight_q[0][0], 60);
      spikes = 4'b0001;
      tick();
      check("a_v0_60", dut.g_node[0].u_neuron.v_q, 60);
      check("a_nodes_0", nodes, 0);
      tick();
      check("a_spike", nodes, 4'b0001);
      check("a_v0_rst", dut.g_node[0].u_neuron.v_q, 0);
`ifdef LIF_REFRACTORY_EN
      tick();
      check("ref1_nodes", nodes, 0);
      check("ref1_v0", dut.g_node[0].u_neuron.v_q, 0);
      tick();
      check("ref2_nodes", nodes, 0);
      check("ref2_v0", dut.g_node[0].u_neuron.v_q, 0);
      tick();
      check("ref_resume_v0", dut.g_node[0].u_neuron.v_q, 60);
      check("ref_resume_nodes", nodes, 0);
      tick();
      check("ref_respike", nodes, 4'b0001);
`else
      tick();
      check("nr_v0_60", dut.g_node[0].u_neuron.v_q, 60);
      check("nr_nodes_0", nodes, 0);
      tick();
      check("nr_respike", nodes, 4'b0001);
      check("nr_v0_rst", dut.g_node[0].u_neuron.v_q, 0);
      tick();
      check("nr_v0_60b", dut.g_node[0].u_neuron.v_q, 60);
`endif
      spikes = 4'b0000;

      // Negative weight clamps potential at zero
      reset_dut();
      write_weight(1, 0, -50);
      check("w10_neg", dut.weight_q[1][0], -50);
      spikes = 4'b0001;
      tick();
      check("neg_v1", dut.g_node[1].u_neuron.v_q, 0);
      check("neg_nodes", nodes, 0);
      tick();
      check("neg_v1_b", dut.g_node[1].u_neuron.v_q, 0);
      spikes = 4'b0000;

      // Wide sum, exact-threshold firing, two neurons in one cycle
      for (int j = 0; j < 4; j++) write_weight(2, j, 127);
      write_weight(3, 3, 100);
      spikes = 4'b1111;
      #1;
      check("syn2_508", dut.syn_w[2], 508);
      check("syn3_100", dut.syn_w[3], 100);
      check("syn1_m50", dut.syn_w[1], -50);
      tick();
      check("multi_spike", nodes, 4'b1100);
      check("multi_v2", dut.g_node[2].u_neuron.v_q, 0);
      check("multi_v1", dut.g_node[1].u_neuron.v_q, 0);
      spikes = 4'b0000;

      // Mid-operation reset discards potential and weights
      reset_dut();
      write_weight(0, 0, 80);
      spikes = 4'b0001;
      tick();
      check("pre_rst_v0", dut.g_node[0].u_neuron.v_q, 80);
      spikes = 4'b0000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_v0", dut.g_node[0].u_neuron.v_q, 0);
      check("mid_rst_nodes", nodes, 0);
      check("mid_rst_w00", dut.weight_q[0][0], 0);
      spikes = 4'b0001;
      tick();
      check("post_rst_v0", dut.g_node[0].u_neuron.v_q, 0);

      // Same-cycle write uses old weight, then leak decay
      we = 1'b1; w_node = 2'd0; w_input = 2'd0; w_data = 8'sd60;
      tick();
      we = 1'b0;
      check("wr_old_v0", dut.g_node[0].u_neuron.v_q, 0);
      check("wr_new_w00", dut.weight_q[0][0], 60);
      tick();
      check("wr_used_v0", dut.g_node[0].u_neuron.v_q, 60);
      spikes = 4'b0000;
      tick();
      check("leak_53", dut.g_node[0].u_neuron.v_q, 53);
      tick();
      check("leak_47", dut.g_node[0].u_neuron.v_q, 47);

      // One below threshold does not fire
      reset_dut();
      write_weight(0, 0, 99);
      spikes = 4'b0001;
      tick();
      check("thr_m1_v0", dut.g_node[0].u_neuron.v_q, 99);
      check("thr_m1_nodes", nodes, 0);
      spikes = 4'b0000;
      tick();
      check("thr_m1_leak", dut.g_node[0].u_neuron.v_q, 87);
      check("thr_m1_nodes_b", nodes, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
